// File: rtl/alu_issue_seq_if.sv
// Bundle of request, response, alu_core and PSW-write signals for alu_issue_seq.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. Once raised, valid is held, and the
// payload is held stable, until that transfer edge. Ready may change freely.
interface alu_issue_seq_if;
    // Request channel
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_opcode;
    logic [7:0] req_op1;
    logic [7:0] req_op2;
    logic [2:0] req_flag_mask;

    // Registered inputs to alu_core
    logic [3:0] alu_opcode;
    logic [7:0] alu_op_in_1;
    logic [7:0] alu_op_in_2;
    logic       alu_carry_in;
    logic       alu_aux_carry_in;

    // Results from alu_core
    logic [7:0] alu_op_out_1;
    logic [7:0] alu_op_out_2;
    logic       alu_carry_out;
    logic       alu_aux_carry_out;
    logic       alu_overflow_out;

    // Direct PSW flag write
    logic       psw_wr;
    logic [2:0] psw_wdata;

    // Response channel
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_res1;
    logic [7:0] rsp_res2;
    logic [2:0] rsp_flags;
    logic       rsp_parity;

    // Sequencer state, for observation only
    logic [1:0] dbg_state;

    modport slave (
        input  req_valid, req_opcode, req_op1, req_op2, req_flag_mask,
        output req_ready,
        output alu_opcode, alu_op_in_1, alu_op_in_2, alu_carry_in, alu_aux_carry_in,
        input  alu_op_out_1, alu_op_out_2, alu_carry_out, alu_aux_carry_out, alu_overflow_out,
        input  psw_wr, psw_wdata,
        output rsp_valid, rsp_res1, rsp_res2, rsp_flags, rsp_parity,
        input  rsp_ready,
        output dbg_state
    );

    modport master (
        output req_valid, req_opcode, req_op1, req_op2, req_flag_mask,
        input  req_ready,
        input  alu_opcode, alu_op_in_1, alu_op_in_2, alu_carry_in, alu_aux_carry_in,
        output alu_op_out_1, alu_op_out_2, alu_carry_out, alu_aux_carry_out, alu_overflow_out,
        output psw_wr, psw_wdata,
        input  rsp_valid, rsp_res1, rsp_res2, rsp_flags, rsp_parity,
        output rsp_ready,
        input  dbg_state
    );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issues one request at a time to alu_core, waits an
// opcode-dependent latency, captures the results, updates CY/AC/OV and
// returns the result over the response handshake.
// Optional feature: define ALU_SEQ_PARITY_EN to produce rsp_parity
// (XOR of rsp_res1, registered with it); otherwise rsp_parity is tied to 0.
module alu_issue_seq #(
    parameter int         ALU_LATENCY    = 1,
    parameter int         MULDIV_LATENCY = 4,
    parameter logic [3:0] MUL_OPCODE     = 4'b1010,
    parameter logic [3:0] DIV_OPCODE     = 4'b1011
) (
    input  logic          clock,
    input  logic          reset,
    alu_issue_seq_if.slave bus
);

    localparam int MAX_LAT = (ALU_LATENCY > MULDIV_LATENCY) ? ALU_LATENCY : MULDIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [3:0]       opc_q,       opc_d;
    logic [7:0]       op1_q,       op1_d;
    logic [7:0]       op2_q,       op2_d;
    logic [2:0]       mask_q,      mask_d;
    logic             cy_q,        cy_d;
    logic             ac_q,        ac_d;
    logic             ov_q,        ov_d;
    logic [7:0]       res1_q,      res1_d;
    logic [7:0]       res2_q,      res2_d;
    logic             rsp_valid_q, rsp_valid_d;
`ifdef ALU_SEQ_PARITY_EN
    logic             parity_q,    parity_d;
`endif

    logic is_muldiv;
    assign is_muldiv = (bus.req_opcode == MUL_OPCODE) || (bus.req_opcode == DIV_OPCODE);

    // Next-state logic: accept in IDLE, count down in WAIT, capture on the
    // last count, hand off in DONE; a direct PSW write overrides any capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opc_d       = opc_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        mask_d      = mask_q;
        cy_d        = cy_q;
        ac_d        = ac_q;
        ov_d        = ov_q;
        res1_d      = res1_q;
        res2_d      = res2_q;
        rsp_valid_d = rsp_valid_q;
`ifdef ALU_SEQ_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    opc_d   = bus.req_opcode;
                    op1_d   = bus.req_op1;
                    op2_d   = bus.req_op2;
                    mask_d  = bus.req_flag_mask;
                    cnt_d   = is_muldiv ? CNT_W'(MULDIV_LATENCY) : CNT_W'(ALU_LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res1_d      = bus.alu_op_out_1;
                    res2_d      = bus.alu_op_out_2;
                    if (mask_q[2]) cy_d = bus.alu_carry_out;
                    if (mask_q[1]) ac_d = bus.alu_aux_carry_out;
                    if (mask_q[0]) ov_d = bus.alu_overflow_out;
`ifdef ALU_SEQ_PARITY_EN
                    parity_d    = ^bus.alu_op_out_1;
`endif
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        if (bus.psw_wr) begin
            cy_d = bus.psw_wdata[2];
            ac_d = bus.psw_wdata[1];
            ov_d = bus.psw_wdata[0];
        end
    end

    // State registers with synchronous reset; reset abandons any operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opc_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            mask_q      <= '0;
            cy_q        <= 1'b0;
            ac_q        <= 1'b0;
            ov_q        <= 1'b0;
            res1_q      <= '0;
            res2_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opc_q       <= opc_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            mask_q      <= mask_d;
            cy_q        <= cy_d;
            ac_q        <= ac_d;
            ov_q        <= ov_d;
            res1_q      <= res1_d;
            res2_q      <= res2_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef ALU_SEQ_PARITY_EN
    // Parity register, loaded alongside rsp_res1 at capture.
    always_ff @(posedge clock) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end
    assign bus.rsp_parity = parity_q;
`else
    assign bus.rsp_parity = 1'b0;
`endif

    assign bus.req_ready        = (state_q == ST_IDLE);
    assign bus.alu_opcode       = opc_q;
    assign bus.alu_op_in_1      = op1_q;
    assign bus.alu_op_in_2      = op2_q;
    // Flags feed straight back so the next request sees freshly updated CY/AC.
    assign bus.alu_carry_in     = cy_q;
    assign bus.alu_aux_carry_in = ac_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_res1         = res1_q;
    assign bus.rsp_res2         = res2_q;
    assign bus.rsp_flags        = {cy_q, ac_q, ov_q};
    assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed requests with the bench
// acting as alu_core, a transaction-level reference model, and a per-cycle
// compare process, plus literal expectations on key results.
module tb_alu_issue_seq;

    localparam int         ALU_LAT = 1;
    localparam int         MD_LAT  = 4;
    localparam logic [3:0] MUL_OP  = 4'b1010;
    localparam logic [3:0] DIV_OP  = 4'b1011;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_issue_seq_if bus();

    alu_issue_seq #(
        .ALU_LATENCY   (ALU_LAT),
        .MULDIV_LATENCY(MD_LAT),
        .MUL_OPCODE    (MUL_OP),
        .DIV_OPCODE    (DIV_OP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: a request is accepted when idle, its result appears
    // exactly "latency" edges later, and it stays until the consumer takes it.
    int         cyc = 0;
    bit         m_pend, m_rsp, m_cap_now;
    int         m_cap_cyc;
    logic [3:0] m_opc;
    logic [7:0] m_op1, m_op2, m_res1, m_res2;
    logic [2:0] m_mask, m_flags;
    logic       m_par;

    function automatic int lat_of(input logic [3:0] opc);
        return (opc == MUL_OP || opc == DIV_OP) ? MD_LAT : ALU_LAT;
    endfunction

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_pend = 0; m_rsp = 0; m_cap_cyc = 0;
            m_opc = '0; m_op1 = '0; m_op2 = '0; m_mask = '0;
            m_res1 = '0; m_res2 = '0; m_flags = '0; m_par = 1'b0;
        end else begin
            m_cap_now = m_pend && (cyc == m_cap_cyc);
            if (m_rsp) begin
                if (bus.rsp_ready) m_rsp = 0;
            end else if (!m_pend && bus.req_valid) begin
                m_pend    = 1;
                m_cap_cyc = cyc + lat_of(bus.req_opcode);
                m_opc     = bus.req_opcode;
                m_op1     = bus.req_op1;
                m_op2     = bus.req_op2;
                m_mask    = bus.req_flag_mask;
            end
            if (m_cap_now) begin
                m_pend = 0;
                m_rsp  = 1;
                m_res1 = bus.alu_op_out_1;
                m_res2 = bus.alu_op_out_2;
                if (m_mask[2]) m_flags[2] = bus.alu_carry_out;
                if (m_mask[1]) m_flags[1] = bus.alu_aux_carry_out;
                if (m_mask[0]) m_flags[0] = bus.alu_overflow_out;
`ifdef ALU_SEQ_PARITY_EN
                m_par = ($countones(bus.alu_op_out_1) % 2) == 1;
`else
                m_par = 1'b0;
`endif
            end
            if (bus.psw_wr) m_flags = bus.psw_wdata;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            check("req_ready",        32'(bus.req_ready),        32'(!(m_pend || m_rsp)));
            check("rsp_valid",        32'(bus.rsp_valid),        32'(m_rsp));
            check("rsp_res1",         32'(bus.rsp_res1),         32'(m_res1));
            check("rsp_res2",         32'(bus.rsp_res2),         32'(m_res2));
            check("rsp_flags",        32'(bus.rsp_flags),        32'(m_flags));
            check("rsp_parity",       32'(bus.rsp_parity),       32'(m_par));
            check("alu_carry_in",     32'(bus.alu_carry_in),     32'(m_flags[2]));
            check("alu_aux_carry_in", 32'(bus.alu_aux_carry_in), 32'(m_flags[1]));
            check("alu_opcode",       32'(bus.alu_opcode),       32'(m_opc));
            check("alu_op_in_1",      32'(bus.alu_op_in_1),      32'(m_op1));
            check("alu_op_in_2",      32'(bus.alu_op_in_2),      32'(m_op2));
        end
    end

    // ---------------- driver tasks ----------------
    // Presents one request for a single accept edge and sets the ALU results
    // the bench (acting as alu_core) returns for it. Ends at the negedge
    // after the accept edge.
    task automatic issue(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] mask, input logic [7:0] r1, input logic [7:0] r2,
                         input logic cy, input logic ac, input logic ov);
        @(negedge clock);
        bus.req_opcode        = opc;
        bus.req_op1           = a;
        bus.req_op2           = b;
        bus.req_flag_mask     = mask;
        bus.alu_op_out_1      = r1;
        bus.alu_op_out_2      = r2;
        bus.alu_carry_out     = cy;
        bus.alu_aux_carry_out = ac;
        bus.alu_overflow_out  = ov;
        bus.req_valid         = 1'b1;
        @(negedge clock);
        bus.req_valid         = 1'b0;
    endtask

    // Counts edges after the accept edge until rsp_valid, bounded.
    task automatic wait_rsp(input string name, input int exp_lat);
        int k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(negedge clock);
            k++;
        end
        check({name, " latency"}, 32'(k), 32'(exp_lat));
    endtask

    // Holds rsp_ready low for "hold" cycles checking stability, then takes it.
    task automatic take_rsp(input string name, input int hold);
        logic [7:0] r1, r2;
        r1 = bus.rsp_res1;
        r2 = bus.rsp_res2;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({name, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({name, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
            check({name, " hold rsp_res1"},  32'(bus.rsp_res1),  32'(r1));
            check({name, " hold rsp_res2"},  32'(bus.rsp_res2),  32'(r2));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check({name, " handoff rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({name, " handoff req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req_valid = 0; bus.req_opcode = '0; bus.req_op1 = '0; bus.req_op2 = '0;
        bus.req_flag_mask = '0; bus.alu_op_out_1 = '0; bus.alu_op_out_2 = '0;
        bus.alu_carry_out = 0; bus.alu_aux_carry_out = 0; bus.alu_overflow_out = 0;
        bus.psw_wr = 0; bus.psw_wdata = '0; bus.rsp_ready = 0;

        @(negedge clock);
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset req_ready",  32'(bus.req_ready),  32'd1);
        check("reset rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("reset rsp_flags",  32'(bus.rsp_flags),  32'd0);
        check("reset alu_opcode", 32'(bus.alu_opcode), 32'd0);

        // T1: ADD-like op, 0x20 + 0x40 -> 0x60, all flags cleared
        issue(4'b0001, 8'h20, 8'h40, 3'b111, 8'h60, 8'h00, 0, 0, 0);
        wait_rsp("t1", 1);
        check("t1 rsp_res1",  32'(bus.rsp_res1),  32'h60);
        check("t1 rsp_flags", 32'(bus.rsp_flags), 32'h0);
        check("t1 rsp_parity", 32'(bus.rsp_parity), 32'd0);
        take_rsp("t1", 1);

        // T2: MUL, only OV updated; latency 4
        issue(MUL_OP, 8'h10, 8'h20, 3'b001, 8'h00, 8'h02, 1, 1, 1);
        wait_rsp("t2", 4);
        check("t2 rsp_res2",  32'(bus.rsp_res2),  32'h02);
        check("t2 rsp_flags", 32'(bus.rsp_flags), 32'b001);
        take_rsp("t2", 0);

        // T3: CY-only update, next request sees the new carry
        issue(4'b0011, 8'hF0, 8'h20, 3'b100, 8'h10, 8'h00, 1, 1, 0);
        wait_rsp("t3", 1);
        check("t3 rsp_flags", 32'(bus.rsp_flags), 32'b101);
        take_rsp("t3", 0);
        issue(4'b0010, 8'h05, 8'h03, 3'b000, 8'h08, 8'h00, 0, 0, 0);
        check("t3b carry_in in WAIT", 32'(bus.alu_carry_in),     32'd1);
        check("t3b aux_in in WAIT",   32'(bus.alu_aux_carry_in), 32'd0);
        wait_rsp("t3b", 1);
        check("t3b mask0 flags", 32'(bus.rsp_flags), 32'b101);
        take_rsp("t3b", 0);

        // T4: psw_wr on the capture edge wins over the ALU flags
        issue(4'b0001, 8'h80, 8'h80, 3'b111, 8'h00, 8'h00, 1, 0, 1);
        bus.psw_wr    = 1'b1;
        bus.psw_wdata = 3'b010;
        @(negedge clock);
        bus.psw_wr    = 1'b0;
        check("t4 rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t4 rsp_flags", 32'(bus.rsp_flags), 32'b010);
        // T5: consumer stalls for 5 cycles
        take_rsp("t5", 5);

        // T6: DIV with parity-odd result and idle PSW write
        issue(DIV_OP, 8'h15, 8'h03, 3'b000, 8'h07, 8'h00, 0, 0, 0);
        wait_rsp("t6", 4);
`ifdef ALU_SEQ_PARITY_EN
        check("t6 rsp_parity", 32'(bus.rsp_parity), 32'd1);
`else
        check("t6 rsp_parity", 32'(bus.rsp_parity), 32'd0);
`endif
        take_rsp("t6", 2);
        @(negedge clock);
        bus.psw_wr = 1'b1; bus.psw_wdata = 3'b111;
        @(negedge clock);
        bus.psw_wr = 1'b0;
        check("t6 idle psw_wr", 32'(bus.rsp_flags), 32'b111);

        // T7: reset during WAIT abandons the request
        issue(MUL_OP, 8'h02, 8'h03, 3'b111, 8'h06, 8'h00, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t7 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t7 req_ready", 32'(bus.req_ready), 32'd1);
        check("t7 flags",     32'(bus.rsp_flags), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("t7 no response", 32'(bus.rsp_valid), 32'd0);
        end

        // T8: back-to-back after reset, carry/aux updated, parity of 0x00
        issue(4'b0001, 8'hFF, 8'h01, 3'b110, 8'h00, 8'h00, 1, 1, 0);
        wait_rsp("t8", 1);
        check("t8 rsp_flags", 32'(bus.rsp_flags), 32'b110);
        take_rsp("t8", 0);
        issue(4'b0100, 8'h0F, 8'h01, 3'b011, 8'h0E, 8'h00, 0, 0, 1);
        check("t8b carry_in", 32'(bus.alu_carry_in),     32'd1);
        check("t8b aux_in",   32'(bus.alu_aux_carry_in), 32'd1);
        wait_rsp("t8b", 1);
        check("t8b rsp_flags", 32'(bus.rsp_flags), 32'b101);
        take_rsp("t8b", 0);

        repeat (3) @(negedge clock);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
